demux_3ch_router: RTL and testbench

Three-channel demultiplexing router with per-channel one-entry output buffers and valid/ready handshakes on every port. It takes one input word stream tagged with a 2-bit channel select and delivers each word to channel A, B or C. It is the distribution-side counterpart of the 3-channel select multiplexer: words fanned out here are recombined there. Select code 3 is illegal; such words are consumed, discarded and counted.

---
 rtl/demux_3ch_router_pkg.sv | 9 +
 rtl/demux_slot.sv | 24 ++
 rtl/demux_3ch_router.sv | 74 +++++++
 tb/tb_demux_3ch_router.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_3ch_router_pkg.sv
// Shared channel codes and select type for the 3-channel demux/mux pair.
package demux_3ch_router_pkg;
  typedef logic [1:0] ch_sel_t;

  localparam ch_sel_t CH_A    = 2'd0;
  localparam ch_sel_t CH_B    = 2'd1;
  localparam ch_sel_t CH_C    = 2'd2;
  localparam ch_sel_t CH_DROP = 2'd3;
endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer: a load always wins, so load+drain in one cycle replaces the word.
module demux_slot #(
  parameter int word_size = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [word_size-1:0] load_data,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [word_size-1:0] out_data
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/demux_3ch_router.sv
// Routes a select-tagged word stream to channels A/B/C; select 3 words are dropped and counted.
// Handshake: a word moves on a port in any cycle where valid && ready; ready never looks at valid.
module demux_3ch_router
  import demux_3ch_router_pkg::*;
#(
  parameter int word_size = 8,
  parameter int cnt_width = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [word_size-1:0] in_data,
  input  ch_sel_t              in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [word_size-1:0] out_a_data,
  output logic                 out_a_valid,
  input  logic                 out_a_ready,
  output logic [word_size-1:0] out_b_data,
  output logic                 out_b_valid,
  input  logic                 out_b_ready,
  output logic [word_size-1:0] out_c_data,
  output logic                 out_c_valid,
  input  logic                 out_c_ready,
  output logic                 drop_pulse,
  output logic [cnt_width-1:0] drop_count
);
  localparam logic [cnt_width-1:0] cnt_one = 1;
  localparam logic [cnt_width-1:0] cnt_max = '1;

  logic accept;
  logic load_a, load_b, load_c, drop;

  // A channel can take a word if empty or draining in this same cycle.
  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      CH_A:    in_ready = !out_a_valid || out_a_ready;
      CH_B:    in_ready = !out_b_valid || out_b_ready;
      CH_C:    in_ready = !out_c_valid || out_c_ready;
      default: in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign load_a = accept && (in_sel == CH_A);
  assign load_b = accept && (in_sel == CH_B);
  assign load_c = accept && (in_sel == CH_C);
  assign drop   = accept && (in_sel == CH_DROP);

  demux_slot #(.word_size(word_size)) u_slot_a (
    .clk(clk), .rst_n(rst_n), .load(load_a), .load_data(in_data),
    .out_ready(out_a_ready), .out_valid(out_a_valid), .out_data(out_a_data)
  );

  demux_slot #(.word_size(word_size)) u_slot_b (
    .clk(clk), .rst_n(rst_n), .load(load_b), .load_data(in_data),
    .out_ready(out_b_ready), .out_valid(out_b_valid), .out_data(out_b_data)
  );

  demux_slot #(.word_size(word_size)) u_slot_c (
    .clk(clk), .rst_n(rst_n), .load(load_c), .load_data(in_data),
    .out_ready(out_c_ready), .out_valid(out_c_valid), .out_data(out_c_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_pulse <= drop;
      if (drop && (drop_count != cnt_max)) drop_count <= drop_count + cnt_one;
    end
  end
endmodule

// File: tb/tb_demux_3ch_router.sv
// Bench for demux_3ch_router: directed scenarios plus randomized traffic against a queue model.
module tb_demux_3ch_router;
  import demux_3ch_router_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  ch_sel_t      in_sel = CH_A;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_a_data, out_b_data, out_c_data;
  logic         out_a_valid, out_b_valid, out_c_valid;
  logic         out_a_ready = 1'b1, out_b_ready = 1'b1, out_c_ready = 1'b1;
  logic         drop_pulse;
  logic [7:0]   drop_count;

  logic         in_ready2;
  logic [W-1:0] a_data2, b_data2, c_data2;
  logic         a_valid2, b_valid2, c_valid2;
  logic         drop_pulse2;
  logic [1:0]   drop_count2;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  demux_3ch_router #(.word_size(W), .cnt_width(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_a_data(out_a_data), .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
    .out_b_data(out_b_data), .out_b_valid(out_b_valid), .out_b_ready(out_b_ready),
    .out_c_data(out_c_data), .out_c_valid(out_c_valid), .out_c_ready(out_c_ready),
    .drop_pulse(drop_pulse), .drop_count(drop_count)
  );

  demux_3ch_router #(.word_size(W), .cnt_width(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready2),
    .out_a_data(a_data2), .out_a_valid(a_valid2), .out_a_ready(out_a_ready),
    .out_b_data(b_data2), .out_b_valid(b_valid2), .out_b_ready(out_b_ready),
    .out_c_data(c_data2), .out_c_valid(c_valid2), .out_c_ready(out_c_ready),
    .drop_pulse(drop_pulse2), .drop_count(drop_count2)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // driver tasks
  task automatic drive(input logic v, input ch_sel_t s, input logic [W-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  task automatic set_ready(input logic a, input logic b, input logic c);
    out_a_ready = a;
    out_b_ready = b;
    out_c_ready = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, CH_A, 8'h00);
    #2;
    checks++;
    if ({out_a_valid, out_b_valid, out_c_valid} !== 3'b000) begin
      failures++; $display("FAIL reset_valid got=%b exp=000", {out_a_valid, out_b_valid, out_c_valid});
    end
    checks++;
    if ({out_a_data, out_b_data, out_c_data} !== 24'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {out_a_data, out_b_data, out_c_data});
    end
    checks++;
    if (drop_pulse !== 1'b0 || drop_count !== 8'd0) begin
      failures++; $display("FAIL reset_drop got=%b/%0d exp=0/0", drop_pulse, drop_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_routing();
    logic [W-1:0] words [3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    apply_reset();
    set_ready(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(1'b1, ch_sel_t'(k), words[k]);
      else drive(1'b0, CH_A, 8'h00);
      #2;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL route_in_ready step=%0d got=%b exp=1", k, in_ready);
      end
      checks++;
      if ({out_a_valid, out_b_valid, out_c_valid} !== ((k == 0) ? 3'b000 : (3'b100 >> (k - 1)))) begin
        failures++; $display("FAIL route_valid step=%0d got=%b", k, {out_a_valid, out_b_valid, out_c_valid});
      end
      if (k == 1 && out_a_data !== 8'h11) begin
        failures++; $display("FAIL route_a got=%h exp=11", out_a_data);
      end
      if (k == 2 && out_b_data !== 8'h22) begin
        failures++; $display("FAIL route_b got=%h exp=22", out_b_data);
      end
      if (k == 3 && out_c_data !== 8'h33) begin
        failures++; $display("FAIL route_c got=%h exp=33", out_c_data);
      end
      if (k > 0) checks++;
      tick();
    end
    checks++;
    if ({out_a_valid, out_b_valid, out_c_valid} !== 3'b000) begin
      failures++; $display("FAIL route_idle got=%b exp=000", {out_a_valid, out_b_valid, out_c_valid});
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_ready(1'b0, 1'b1, 1'b1);
    drive(1'b1, CH_A, 8'hA0);
    #2;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_first_ready got=%b exp=1", in_ready); end
    tick();
    drive(1'b1, CH_A, 8'hA1);
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (in_ready !== 1'b0 || out_a_valid !== 1'b1 || out_a_data !== 8'hA0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got=rdy%b v%b d%h exp=rdy0 v1 dA0", i, in_ready, out_a_valid, out_a_data);
      end
      tick();
    end
    out_a_ready = 1'b1;
    #2;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    tick();
    drive(1'b0, CH_A, 8'h00);
    out_a_ready = 1'b0;
    #2;
    checks++;
    if (out_a_valid !== 1'b1 || out_a_data !== 8'hA1) begin
      failures++; $display("FAIL bp_second got=v%b d%h exp=v1 dA1", out_a_valid, out_a_data);
    end
  endtask

  // continues from backpressure: A is full with A1 and stalled
  task automatic test_independence();
    drive(1'b1, CH_B, 8'hB5);
    #2;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL indep_ready got=%b exp=1", in_ready); end
    tick();
    drive(1'b0, CH_A, 8'h00);
    #2;
    checks++;
    if (out_b_valid !== 1'b1 || out_b_data !== 8'hB5) begin
      failures++; $display("FAIL indep_b got=v%b d%h exp=v1 dB5", out_b_valid, out_b_data);
    end
    checks++;
    if (out_a_valid !== 1'b1 || out_a_data !== 8'hA1) begin
      failures++; $display("FAIL indep_a got=v%b d%h exp=v1 dA1", out_a_valid, out_a_data);
    end
    set_ready(1'b1, 1'b1, 1'b1);
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    apply_reset();
    set_ready(1'b1, 1'b1, 1'b1);
    exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) begin
        d = W'($urandom_range(0, 255));
        drive(1'b1, CH_C, d);
      end else drive(1'b0, CH_A, 8'h00);
      #2;
      if (i > 0) begin
        checks++;
        if (out_c_valid !== 1'b1 || exp_q.size() == 0 || out_c_data !== exp_q[0]) begin
          failures++;
          $display("FAIL b2b_word idx=%0d got=v%b d%h exp=v1 d%h", i - 1, out_c_valid, out_c_data,
                   (exp_q.size() != 0) ? exp_q[0] : 8'h00);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (i < 16) begin
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready idx=%0d got=%b exp=1", i, in_ready); end
        if (in_ready === 1'b1) exp_q.push_back(d);
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0 || out_c_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_end left=%0d valid=%b exp=0/0", exp_q.size(), out_c_valid);
    end
  endtask

  task automatic test_drops();
    apply_reset();
    set_ready(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, CH_DROP, W'($urandom_range(0, 255)));
      else drive(1'b0, CH_A, 8'h00);
      #2;
      checks++;
      if (drop_pulse !== ((i >= 1 && i <= 3) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL drop_pulse cyc=%0d got=%b", i, drop_pulse);
      end
      checks++;
      if (in_ready !== 1'b1 || {out_a_valid, out_b_valid, out_c_valid} !== 3'b000) begin
        failures++; $display("FAIL drop_side cyc=%0d got=rdy%b v%b", i, in_ready, {out_a_valid, out_b_valid, out_c_valid});
      end
      tick();
    end
    checks++;
    if (drop_count !== 8'd3) begin failures++; $display("FAIL drop_count got=%0d exp=3", drop_count); end
    apply_reset();
    drive(1'b1, CH_DROP, 8'h5A);
    for (int i = 0; i < 5; i++) tick();
    drive(1'b0, CH_A, 8'h00);
    tick();
    checks++;
    if (drop_count !== 8'd5) begin failures++; $display("FAIL drop_count5 got=%0d exp=5", drop_count); end
    checks++;
    if (drop_count2 !== 2'd3) begin failures++; $display("FAIL drop_saturate got=%0d exp=3", drop_count2); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_ready(1'b0, 1'b0, 1'b1);
    drive(1'b1, CH_A, 8'h5A); tick();
    drive(1'b1, CH_B, 8'h6B); tick();
    drive(1'b1, CH_DROP, 8'h00); tick();
    drive(1'b0, CH_A, 8'h00);
    #2;
    checks++;
    if (out_a_valid !== 1'b1 || out_b_valid !== 1'b1 || drop_count !== 8'd1) begin
      failures++; $display("FAIL rmid_pre got=a%b b%b cnt%0d exp=1 1 1", out_a_valid, out_b_valid, drop_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_a_valid, out_b_valid, out_c_valid} !== 3'b000 || drop_count !== 8'd0 || out_a_data !== 8'h00) begin
      failures++; $display("FAIL rmid_async got=v%b cnt%0d da%h exp=000 0 00",
                           {out_a_valid, out_b_valid, out_c_valid}, drop_count, out_a_data);
    end
    #1;
    rst_n = 1'b1;
    tick();
    set_ready(1'b1, 1'b1, 1'b1);
    drive(1'b1, CH_B, 8'h77);
    tick();
    drive(1'b0, CH_A, 8'h00);
    #2;
    checks++;
    if (out_b_valid !== 1'b1 || out_b_data !== 8'h77 || out_a_valid !== 1'b0) begin
      failures++; $display("FAIL rmid_after got=b%b d%h a%b exp=1 77 0", out_b_valid, out_b_data, out_a_valid);
    end
  endtask

  // Reference: each channel is a queue of at most one word; count saturates at the width limit.
  task automatic test_random();
    logic [W-1:0] mq[3][$];
    logic         rdy[3];
    logic         obs_v[3];
    logic [W-1:0] obs_d[3];
    int           exp_cnt;
    logic         exp_pulse;
    logic         exp_rdy;
    logic         acc;
    int           s;
    logic [W-1:0] d;
    apply_reset();
    exp_cnt = 0;
    exp_pulse = 1'b0;
    for (int i = 0; i < 400; i++) begin
      s = $urandom_range(0, 3);
      d = W'($urandom_range(0, 255));
      for (int k = 0; k < 3; k++) rdy[k] = ($urandom_range(0, 2) != 0);
      drive(($urandom_range(0, 3) != 0), ch_sel_t'(s), d);
      set_ready(rdy[0], rdy[1], rdy[2]);
      #2;
      obs_v[0] = out_a_valid; obs_v[1] = out_b_valid; obs_v[2] = out_c_valid;
      obs_d[0] = out_a_data;  obs_d[1] = out_b_data;  obs_d[2] = out_c_data;
      exp_rdy = (s == 3) ? 1'b1 : ((mq[s].size() == 0) || rdy[s]);
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++; $display("FAIL rand_ready cyc=%0d sel=%0d got=%b exp=%b", i, s, in_ready, exp_rdy);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_v[k] !== (mq[k].size() != 0) || (mq[k].size() != 0 && obs_d[k] !== mq[k][0])) begin
          failures++;
          $display("FAIL rand_out cyc=%0d ch=%0d got=v%b d%h exp=v%b d%h", i, k, obs_v[k], obs_d[k],
                   mq[k].size() != 0, (mq[k].size() != 0) ? mq[k][0] : 8'h00);
        end
      end
      checks++;
      if (drop_pulse !== exp_pulse || drop_count !== 8'(exp_cnt) ||
          drop_count2 !== 2'((exp_cnt > 3) ? 3 : exp_cnt)) begin
        failures++; $display("FAIL rand_drop cyc=%0d got=p%b c%0d c2=%0d exp=p%b c%0d", i,
                             drop_pulse, drop_count, drop_count2, exp_pulse, exp_cnt);
      end
      acc = in_valid && exp_rdy;
      for (int k = 0; k < 3; k++)
        if (mq[k].size() != 0 && rdy[k]) void'(mq[k].pop_front());
      if (acc && s != 3) mq[s].push_back(d);
      exp_pulse = acc && (s == 3);
      if (exp_pulse && exp_cnt < 255) exp_cnt++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_routing();
    test_backpressure();
    test_independence();
    test_back_to_back();
    test_drops();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end
endmodule
